// File: rtl/axi4_pkg.sv
// Shared AXI4 / AXI4-Stream types, constants and helpers for the stream
// generators and checkers.
package axi4_pkg;

  localparam int unsigned AXIS_DATA_W = 64;
  localparam int unsigned AXIS_KEEP_W = AXIS_DATA_W / 8;
  localparam int unsigned AXIS_ID_W   = 4;
  localparam int unsigned AXIS_DEST_W = 4;
  localparam int unsigned AXIS_USER_W = 1;

  typedef logic [AXIS_DATA_W-1:0] axi_data_t;
  typedef logic [AXIS_KEEP_W-1:0] axi_keep_t;
  typedef logic [AXIS_ID_W-1:0]   axi_id_t;
  typedef logic [AXIS_DEST_W-1:0] axi_dest_t;
  typedef logic [AXIS_USER_W-1:0] axi_user_t;

  // All bytes of a beat valid.
  localparam axi_keep_t AXIS_KEEP_ALL = '1;

  // Traffic generator control states.
  typedef enum logic [1:0] {
    AXIS_GEN_IDLE = 2'd0,
    AXIS_GEN_SEND = 2'd1,
    AXIS_GEN_GAP  = 2'd2
  } axis_gen_state_t;

  // Deterministic payload: seed + (pkt << 16) + beat, 64-bit wraparound.
  // Indices are zero-extended, so generators and sinks agree bit-for-bit.
  function automatic axi_data_t axis_gen_pattern(input axi_data_t   seed,
                                                 input logic [31:0] pkt,
                                                 input logic [31:0] beat);
    axi_data_t pkt_ext;
    axi_data_t beat_ext;
    pkt_ext  = {32'd0, pkt};
    beat_ext = {32'd0, beat};
    return seed + (pkt_ext << 16) + beat_ext;
  endfunction

endpackage

// File: rtl/axi_stream_interface.sv
// AXI4-Stream bundle with master and slave views.
interface axi_stream_interface;
  import axi4_pkg::*;

  logic      tvalid;
  logic      tready;
  axi_data_t tdata;
  axi_keep_t tkeep;
  axi_keep_t tstrb;
  logic      tlast;
  axi_id_t   tid;
  axi_dest_t tdest;
  axi_user_t tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/axis_traffic_gen.sv
// AXI4-Stream burst generator: on start, sends cfg_pkts+1 packets of
// cfg_beats+1 beats with a deterministic payload, optional idle gaps
// between packets and a configurable tkeep on each packet's last beat.
module axis_traffic_gen
  import axi4_pkg::*;
#(
  parameter int unsigned ID    = 0,
  parameter logic [63:0] SEED  = 64'hdeadbeef00000000,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  axi_dest_t        dest,
  input  logic [CNT_W-1:0] cfg_beats,
  input  logic [CNT_W-1:0] cfg_pkts,
  input  logic [CNT_W-1:0] cfg_gap,
  input  axi_keep_t        cfg_last_keep,
  axi_stream_interface.master axis,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  axis_gen_state_t  state_q,     state_d;
  logic [CNT_W-1:0] beat_idx_q,  beat_idx_d;
  logic [CNT_W-1:0] pkt_idx_q,   pkt_idx_d;
  logic [CNT_W-1:0] gap_cnt_q,   gap_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_q,   pkt_cnt_d;
  logic             done_q,      done_d;
  axi_dest_t        dest_q,      dest_d;
  logic [CNT_W-1:0] beats_q,     beats_d;
  logic [CNT_W-1:0] pkts_q,      pkts_d;
  logic [CNT_W-1:0] gap_q,       gap_d;
  axi_keep_t        last_keep_q, last_keep_d;

  logic send_w;
  logic last_w;
  logic hs_w;

  // Output decode uses registered state only; tready never reaches an output.
  assign send_w = (state_q == AXIS_GEN_SEND);
  assign last_w = send_w && (beat_idx_q == beats_q);
  assign hs_w   = send_w && axis.tready;

  // Next-state, counter and config-latch logic.
  always_comb begin
    state_d     = state_q;
    beat_idx_d  = beat_idx_q;
    pkt_idx_d   = pkt_idx_q;
    gap_cnt_d   = gap_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    done_d      = 1'b0;
    dest_d      = dest_q;
    beats_d     = beats_q;
    pkts_d      = pkts_q;
    gap_d       = gap_q;
    last_keep_d = last_keep_q;

    unique case (state_q)
      AXIS_GEN_IDLE: begin
        if (start) begin
          state_d    = AXIS_GEN_SEND;
          dest_d     = dest;
          beats_d    = cfg_beats;
          pkts_d     = cfg_pkts;
          gap_d      = cfg_gap;
          // Resolve the "0 means full beat" encoding once, at latch time.
          last_keep_d = (cfg_last_keep == '0) ? AXIS_KEEP_ALL : cfg_last_keep;
          pkt_cnt_d  = '0;
          pkt_idx_d  = '0;
          beat_idx_d = '0;
        end
      end

      AXIS_GEN_SEND: begin
        if (hs_w) begin
          if (last_w) begin
            pkt_cnt_d  = pkt_cnt_q + CNT_ONE;
            pkt_idx_d  = pkt_idx_q + CNT_ONE;
            beat_idx_d = '0;
            // Terminal compare uses the pre-increment index so a full
            // 2^CNT_W-packet burst ends before the counter wraps.
            if (pkt_idx_q == pkts_q) begin
              state_d = AXIS_GEN_IDLE;
              done_d  = 1'b1;
            end else if (gap_q != '0) begin
              state_d   = AXIS_GEN_GAP;
              gap_cnt_d = gap_q - CNT_ONE;
            end
          end else begin
            beat_idx_d = beat_idx_q + CNT_ONE;
          end
        end
      end

      AXIS_GEN_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = AXIS_GEN_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = AXIS_GEN_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= AXIS_GEN_IDLE;
      beat_idx_q  <= '0;
      pkt_idx_q   <= '0;
      gap_cnt_q   <= '0;
      pkt_cnt_q   <= '0;
      done_q      <= 1'b0;
      dest_q      <= '0;
      beats_q     <= '0;
      pkts_q      <= '0;
      gap_q       <= '0;
      last_keep_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      pkt_idx_q   <= pkt_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      done_q      <= done_d;
      dest_q      <= dest_d;
      beats_q     <= beats_d;
      pkts_q      <= pkts_d;
      gap_q       <= gap_d;
      last_keep_q <= last_keep_d;
    end
  end

  // Payload fields depend only on registered indices, so they hold steady
  // while a beat is stalled.
  assign axis.tvalid = send_w;
  assign axis.tlast  = last_w;
  assign axis.tdata  = axis_gen_pattern(SEED, 32'(pkt_idx_q), 32'(beat_idx_q));
  assign axis.tkeep  = last_w ? last_keep_q : AXIS_KEEP_ALL;
  assign axis.tstrb  = last_w ? last_keep_q : AXIS_KEEP_ALL;
  assign axis.tid    = axi_id_t'(ID);
  assign axis.tdest  = dest_q;
  assign axis.tuser  = '0;

  assign busy    = (state_q != AXIS_GEN_IDLE);
  assign done    = done_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule
